dom_mul_gf2_arbiter: RTL and testbench

- Round-robin scheduler that time-multiplexes one pipelined DOM GF(2^2) shared multiplier (real_dom_shared_mul_gf2, PIPELINED=1) between NREQ requesters.
- Gates each issue on fresh randomness (Z, B) and drives the multiplier ports directly.
- Tracks in-flight operations with a tag pipeline and routes each masked product back to the requester that issued it.
- Sits between the S-box inversion sequencers and the shared multiplier instance.

---
 rtl/dom_mul_gf2_arbiter.sv | 107 ++++++++++
 tb/tb_dom_mul_gf2_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dom_mul_gf2_arbiter.sv
// dom_mul_gf2_arbiter: round-robin scheduler sharing one pipelined DOM GF(2^2) multiplier
// between NREQ requesters, gated on fresh randomness, with tag-based response routing.
module dom_mul_gf2_arbiter #(
    parameter int SHARES  = 2,
    parameter int NREQ    = 4,
    parameter int LATENCY = 1,
    parameter int CNTW    = 16
) (
    input  logic                          ClkxCI,
    input  logic                          RstxRI,
    input  logic                          EnxSI,
    input  logic [NREQ-1:0]               ReqValidxSI,
    output logic [NREQ-1:0]               ReqReadyxSO,
    input  logic [NREQ*2*SHARES-1:0]      ReqXxDI,
    input  logic [NREQ*2*SHARES-1:0]      ReqYxDI,
    input  logic                          RandValidxSI,
    input  logic [SHARES*(SHARES-1)-1:0]  RandZxDI,
    input  logic [2*SHARES-1:0]           RandBxDI,
    output logic                          RandReadyxSO,
    output logic [2*SHARES-1:0]           MulXxDO,
    output logic [2*SHARES-1:0]           MulYxDO,
    output logic [SHARES*(SHARES-1)-1:0]  MulZxDO,
    output logic [2*SHARES-1:0]           MulBxDO,
    input  logic [2*SHARES-1:0]           MulQxDI,
    output logic [NREQ-1:0]               RspValidxSO,
    output logic [2*SHARES-1:0]           RspQxDO,
    output logic                          IdlexSO,
    output logic [CNTW-1:0]               IssueCntxDO
);
    localparam int W  = 2 * SHARES;
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                       r_state, w_state_nx;
    logic [PW-1:0]                r_ptr, w_gnt;
    logic                         w_found, w_issue, w_drain_done;
    logic [LATENCY-1:0]           r_tag_v;
    logic [LATENCY-1:0][PW-1:0]   r_tag_id;
    logic [CNTW-1:0]              r_cnt;

    // Descending scan so the last hit is the one closest to the pointer.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (ReqValidxSI[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_gnt   = PW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_issue = (r_state == RUN) && EnxSI && RandValidxSI && w_found;

    // Drain finishes when the pipeline will be empty after this edge, i.e. only
    // the output stage may still hold an op.
    always_comb begin
        w_drain_done = 1'b1;
        for (int k = 0; k < LATENCY - 1; k++)
            if (r_tag_v[k]) w_drain_done = 1'b0;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    w_state_nx = EnxSI ? RUN : IDLE;
            RUN:     w_state_nx = EnxSI ? RUN : DRAIN;
            DRAIN:   w_state_nx = EnxSI ? RUN : (w_drain_done ? IDLE : DRAIN);
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_tag_v  <= '0;
            r_tag_id <= '0;
            r_cnt    <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_tag_v[0]  <= w_issue;
            r_tag_id[0] <= w_gnt;
            for (int k = 1; k < LATENCY; k++) begin
                r_tag_v[k]  <= r_tag_v[k-1];
                r_tag_id[k] <= r_tag_id[k-1];
            end
            if (w_issue) begin
                r_ptr <= (w_gnt == PW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Multiplier inputs are zeroed when idle so stale shares never reach it.
    assign ReqReadyxSO  = w_issue ? (NREQ'(1) << w_gnt) : '0;
    assign RandReadyxSO = w_issue;
    assign MulXxDO      = w_issue ? ReqXxDI[w_gnt*W +: W] : '0;
    assign MulYxDO      = w_issue ? ReqYxDI[w_gnt*W +: W] : '0;
    assign MulZxDO      = w_issue ? RandZxDI : '0;
    assign MulBxDO      = w_issue ? RandBxDI : '0;
    assign RspValidxSO  = r_tag_v[LATENCY-1] ? (NREQ'(1) << r_tag_id[LATENCY-1]) : '0;
    assign RspQxDO      = r_tag_v[LATENCY-1] ? MulQxDI : '0;
    assign IdlexSO      = (r_state == IDLE) && !(|r_tag_v);
    assign IssueCntxDO  = r_cnt;
endmodule

// File: tb/tb_dom_mul_gf2_arbiter.sv
// tb_dom_mul_gf2_arbiter: randomized scoreboard bench for dom_mul_gf2_arbiter with a
// behavioural masked-multiplier environment and a cycle-level arbitration model.
module tb_dom_mul_gf2_arbiter;
    localparam int NREQ = 4;
    localparam int LAT  = 3;
    localparam int CNTW = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

    logic        clk = 1'b0;
    logic        RstxRI = 1'b1, EnxSI = 1'b0, RandValidxSI = 1'b0;
    logic [3:0]  ReqValidxSI = '0, ReqReadyxSO, RspValidxSO;
    logic [15:0] ReqXxDI = '0, ReqYxDI = '0;
    logic [1:0]  RandZxDI = '0, MulZxDO;
    logic [3:0]  RandBxDI = '0, MulXxDO, MulYxDO, MulBxDO, MulQxDI, RspQxDO;
    logic        RandReadyxSO, IdlexSO;
    logic [3:0]  IssueCntxDO;

    dom_mul_gf2_arbiter #(.SHARES(2), .NREQ(NREQ), .LATENCY(LAT), .CNTW(CNTW)) dut (
        .ClkxCI(clk), .RstxRI(RstxRI), .EnxSI(EnxSI),
        .ReqValidxSI(ReqValidxSI), .ReqReadyxSO(ReqReadyxSO),
        .ReqXxDI(ReqXxDI), .ReqYxDI(ReqYxDI),
        .RandValidxSI(RandValidxSI), .RandZxDI(RandZxDI), .RandBxDI(RandBxDI),
        .RandReadyxSO(RandReadyxSO),
        .MulXxDO(MulXxDO), .MulYxDO(MulYxDO), .MulZxDO(MulZxDO), .MulBxDO(MulBxDO),
        .MulQxDI(MulQxDI), .RspValidxSO(RspValidxSO), .RspQxDO(RspQxDO),
        .IdlexSO(IdlexSO), .IssueCntxDO(IssueCntxDO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] gfmul(logic [1:0] a, logic [1:0] b);
        return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]), (a[1] & b[1]) ^ (a[0] & b[0])};
    endfunction

    // Masked product: share1 is a mask drawn from Z and B, share0 = product ^ mask.
    function automatic logic [3:0] mulq(logic [3:0] x, logic [3:0] y, logic [1:0] z, logic [3:0] b);
        logic [1:0] m;
        m = b[3:2] ^ b[1:0] ^ z;
        return {m, gfmul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]) ^ m};
    endfunction

    logic [3:0] mq [LAT];
    always @(posedge clk) begin
        mq[0] <= mulq(MulXxDO, MulYxDO, MulZxDO, MulBxDO);
        for (int k = 1; k < LAT; k++) mq[k] <= mq[k-1];
    end
    assign MulQxDI = mq[LAT-1];

    typedef struct {int due; int id; logic [3:0] q; logic [1:0] p;} exp_t;
    exp_t sb[$];

    int checks = 0, errors = 0;
    int m_mode = M_IDLE, m_ptr = 0, m_cnt = 0, m_last_due = -1;
    bit m_known = 0, m_prev_rst = 0, use_f = 0;
    logic [15:0] fx, fy;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", n, cyc, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic rst, input logic rv, input logic [3:0] rq);
        int g, c;
        logic [3:0] ex, ey;
        @(posedge clk);
        #1;
        if (m_prev_rst) m_known = 1;
        c = cyc;
        RstxRI = rst; EnxSI = en; RandValidxSI = rv; ReqValidxSI = rq;
        ReqXxDI = use_f ? fx : 16'($urandom);
        ReqYxDI = use_f ? fy : 16'($urandom);
        RandZxDI = 2'($urandom);
        RandBxDI = 4'($urandom);
        g = -1;
        if (m_mode == M_RUN && en && rv)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && rq[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        ex = (g >= 0) ? ReqXxDI[g*4 +: 4] : 4'h0;
        ey = (g >= 0) ? ReqYxDI[g*4 +: 4] : 4'h0;
        if (g >= 0 && !rst) begin
            sb.push_back('{c + LAT, g, mulq(ex, ey, RandZxDI, RandBxDI),
                           gfmul(ex[3:2] ^ ex[1:0], ey[3:2] ^ ey[1:0])});
            m_last_due = c + LAT;
        end
        #1;
        if (m_known) begin
            chk("req_ready", 32'(ReqReadyxSO), (g >= 0) ? 32'(1) << g : 0);
            chk("rand_ready", 32'(RandReadyxSO), 32'(g >= 0));
            chk("mul_x", 32'(MulXxDO), 32'(ex));
            chk("mul_y", 32'(MulYxDO), 32'(ey));
            chk("mul_z", 32'(MulZxDO), (g >= 0) ? 32'(RandZxDI) : 0);
            chk("mul_b", 32'(MulBxDO), (g >= 0) ? 32'(RandBxDI) : 0);
            chk("idle", 32'(IdlexSO), 32'(m_mode == M_IDLE && m_last_due < c));
            chk("issue_cnt", 32'(IssueCntxDO), 32'(m_cnt));
        end
        m_prev_rst = rst;
        if (rst) begin
            m_mode = M_IDLE; m_ptr = 0; m_cnt = 0; m_last_due = -1;
            while (sb.size() > 0 && sb[$].due > c) void'(sb.pop_back());
        end else begin
            if (g >= 0) begin
                m_ptr = (g + 1) % NREQ;
                m_cnt = (m_cnt + 1) % (1 << CNTW);
            end
            if (m_mode == M_IDLE) m_mode = en ? M_RUN : M_IDLE;
            else if (m_mode == M_RUN) m_mode = en ? M_RUN : M_DRAIN;
            else m_mode = en ? M_RUN : (m_last_due <= c ? M_IDLE : M_DRAIN);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (m_known) begin
            if (RspValidxSO != 0) begin
                if (sb.size() == 0 || sb[0].due != cyc) chk("rsp_unexpected", 32'(RspValidxSO), 0);
                else begin
                    e = sb.pop_front();
                    chk("rsp_valid", 32'(RspValidxSO), 32'(1) << e.id);
                    chk("rsp_q", 32'(RspQxDO), 32'(e.q));
                    chk("rsp_product", 32'(RspQxDO[3:2] ^ RspQxDO[1:0]), 32'(e.p));
                end
            end else begin
                chk("rsp_q_zero", 32'(RspQxDO), 0);
                if (sb.size() > 0 && sb[0].due <= cyc) begin
                    e = sb.pop_front();
                    chk("rsp_missing", 32'(RspValidxSO), 32'(1) << e.id);
                end
            end
        end
    end

    initial begin
        repeat (2) step(0, 1, 0, 4'h0);
        step(1, 0, 0, 4'h0);
        fx = '0; fy = '0;
        fx[8 +: 4] = 4'b1101;
        fy[8 +: 4] = 4'b0010;
        use_f = 1;
        step(1, 0, 1, 4'b0100);
        use_f = 0;
        repeat (4) step(1, 0, 0, 4'h0);
        step(0, 1, 0, 4'h0);
        step(1, 0, 0, 4'h0);
        repeat (8) step(1, 0, 1, 4'hf);
        repeat (LAT + 1) step(1, 0, 0, 4'h0);
        repeat (3) step(1, 0, 0, 4'b0010);
        step(1, 0, 1, 4'b0010);
        repeat (4) step(1, 0, 0, 4'h0);
        repeat (3) step(1, 0, 1, 4'hf);
        repeat (7) step(0, 0, 1, 4'hf);
        step(1, 0, 0, 4'h0);
        step(1, 0, 1, 4'b1000);
        step(1, 1, 0, 4'h0);
        repeat (5) step(1, 0, 0, 4'h0);
        repeat (400) step($urandom_range(0, 7) != 0, $urandom_range(0, 60) == 0,
                          $urandom_range(0, 3) != 0, 4'($urandom));
        repeat (LAT + 3) step(0, 0, 0, 4'h0);
        chk("scoreboard_empty", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
